gate_response_checker: RTL and testbench

GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

---
 rtl/gate_chk_pkg.sv | 18 +
 rtl/gate_ref_model.sv | 12 +
 rtl/gate_response_checker.sv | 114 +++++++++++
 tb/tb_gate_response_checker.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// rtl/gate_chk_pkg.sv - shared FSM state, vector count and error counter width for the gate checker
package gate_chk_pkg;

  localparam int VEC_COUNT = 4;
  localparam int IDX_W     = 2;
  localparam int ERR_W     = 3;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// rtl/gate_ref_model.sv - golden XOR/XNOR values for the operands currently driven
module gate_ref_model (
  input  logic a,
  input  logic b,
  output logic exp_xor,
  output logic exp_xnor
);

  assign exp_xor  = a ^ b;
  assign exp_xnor = ~(a ^ b);

endmodule

// File: rtl/gate_response_checker.sv
// rtl/gate_response_checker.sv - exhaustive XOR/XNOR gate checker over the four {a,b} vectors
// GATE_CHK_LOOP_EN: restart from vector 0 after each pass until abort or rst.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 xor_in,
  input  logic                 xnor_in,
  output logic                 a_out,
  output logic                 b_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [VEC_COUNT-1:0] fail_vec,
  output logic [ERR_W-1:0]     err_count
);

  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_COUNT - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       settle_cnt;
  logic             exp_xor;
  logic             exp_xnor;
  logic             mismatch;

  gate_ref_model u_ref (
    .a       (a_out),
    .b       (b_out),
    .exp_xor (exp_xor),
    .exp_xnor(exp_xnor)
  );

  assign mismatch = (xor_in != exp_xor) || (xnor_in != exp_xnor);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_vec   <= '0;
      err_count  <= '0;
    end else begin
      done <= 1'b0;
      // Abort wins over every transition; the error record is left intact.
      if (abort) begin
        state <= ST_IDLE;
        pass  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state     <= ST_DRIVE;
              idx       <= '0;
              fail_vec  <= '0;
              err_count <= '0;
              pass      <= 1'b0;
            end
          end
          ST_DRIVE: begin
            {a_out, b_out} <= idx;
            settle_cnt     <= '0;
            state          <= (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
          end
          ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state <= ST_SAMPLE;
            end else begin
              settle_cnt <= settle_cnt + 4'd1;
            end
          end
          ST_SAMPLE: begin
            if (mismatch) begin
              fail_vec[idx] <= 1'b1;
              if (err_count != ERR_MAX) begin
                err_count <= err_count + 1'b1;
              end
            end
            // done is raised on entry so it is visible during the DONE cycle itself.
            if (idx == IDX_LAST) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_DRIVE;
            end
          end
          ST_DONE: begin
            pass <= (fail_vec == '0);
`ifdef GATE_CHK_LOOP_EN
            idx   <= '0;
            state <= ST_DRIVE;
`else
            state <= ST_IDLE;
`endif
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// tb/tb_gate_response_checker.sv - directed bench for gate_response_checker (GATE_CHK_LOOP_EN selects loop-mode checks)
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic       start0, start1;
  logic [1:0] mode0;
  logic       a0, b0, busy0, done0, pass0, xor0, xnor0;
  logic       a1, b1, busy1, done1, pass1, xor1, xnor1;
  logic [3:0] fv0, fv1;
  logic [2:0] ec0, ec1;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  // Gate under test for u0: mode 0 correct, 1 xnor stuck at 0, 2 xor wired as AND.
  assign xor0  = (mode0 == 2'd2) ? (a0 & b0) : (a0 ^ b0);
  assign xnor0 = (mode0 == 2'd1) ? 1'b0 : ~(a0 ^ b0);
  assign xor1  = a1 ^ b1;
  assign xnor1 = ~(a1 ^ b1);

  gate_response_checker #(.SETTLE_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort),
    .xor_in(xor0), .xnor_in(xnor0), .a_out(a0), .b_out(b0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_vec(fv0), .err_count(ec0)
  );

  gate_response_checker #(.SETTLE_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .xor_in(xor1), .xnor_in(xnor1), .a_out(a1), .b_out(b1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_vec(fv1), .err_count(ec1)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start0();
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
  endtask

  task automatic run0(input logic [1:0] m, input bit restart, input logic [3:0] exp_fv,
                      input logic [2:0] exp_ec, input logic exp_pass);
    int cyc;
    mode0 = m;
    pulse_start0();
    cyc = 1;
    while (!done0 && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
      if (restart) start0 = (cyc == 5);
    end
    start0 = 1'b0;
    chk("done_cycle", 8'(cyc), 8'd13);
    chk("fail_vec", {4'd0, fv0}, {4'd0, exp_fv});
    chk("err_count", {5'd0, ec0}, {5'd0, exp_ec});
    @(posedge clk);
    #1;
    chk("done_width", {7'd0, done0}, 8'd0);
    chk("pass", {7'd0, pass0}, {7'd0, exp_pass});
    chk("busy_after", {7'd0, busy0}, 8'd0);
  endtask

  initial begin
    int cyc;
    bit seen;
    rst = 1'b1; abort = 1'b0; start0 = 1'b0; start1 = 1'b0; mode0 = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_u0", {a0, b0, busy0, done0, pass0, ec0}, 8'd0);
    chk("rst_fv0", {4'd0, fv0}, 8'd0);
    chk("rst_u1", {a1, b1, busy1, done1, pass1, ec1}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef GATE_CHK_LOOP_EN
    begin
      int nf;
      logic [1:0] pmode [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
      nf = 0;
      mode0 = pmode[0];
      pulse_start0();
      for (int p = 0; p < 6; p++) begin
        cyc = 0;
        while (!done0 && cyc < 20) begin
          @(posedge clk);
          #1 cyc++;
        end
        if (pmode[p] != 2'd0) nf++;
        chk("loop_done", {7'd0, done0}, 8'd1);
        chk("loop_err", {5'd0, ec0}, (nf * 2 > 7) ? 8'd7 : 8'(nf * 2));
        if (p < 5) mode0 = pmode[p+1];
        @(posedge clk);
        #1;
        chk("loop_fv", {4'd0, fv0}, (nf > 0) ? 8'h09 : 8'h00);
        chk("loop_pass", {7'd0, pass0}, (nf == 0) ? 8'd1 : 8'd0);
        chk("loop_busy", {7'd0, busy0}, 8'd1);
      end
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      chk("loop_abort_busy", {7'd0, busy0}, 8'd0);
    end
`else
    // Correct gate, then the two faulty gates, with a start pulse ignored mid-run.
    run0(2'd0, 1'b0, 4'b0000, 3'd0, 1'b1);
    run0(2'd1, 1'b1, 4'b1001, 3'd2, 1'b0);
    run0(2'd2, 1'b0, 4'b1110, 3'd3, 1'b0);

    // SETTLE_CYCLES=0: operands step every two cycles, done at cycle 9.
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
      if (cyc >= 2 && cyc <= 8 && (cyc % 2) == 0) chk("ab_step", {6'd0, a1, b1}, 8'((cyc - 2) / 2));
    end
    chk("done_cycle_s0", 8'(cyc), 8'd9);
    @(posedge clk);
    #1;
    chk("pass_s0", {3'd0, pass1, fv1}, 8'h10);

    // start and abort together in IDLE stay in IDLE.
    @(negedge clk);
    start0 = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {7'd0, busy0}, 8'd0);

    // Abort once vector 2 is on the operands.
    mode0 = 2'd1;
    pulse_start0();
    cyc = 1;
    while ({a0, b0} != 2'b10 && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("abort_reach_v2", {6'd0, a0, b0}, 8'h02);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_state", {5'd0, busy0, done0, pass0}, 8'd0);
    chk("abort_hold_fv", {4'd0, fv0}, 8'h01);
    chk("abort_hold_ec", {5'd0, ec0}, 8'd1);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1 if (done0) seen = 1'b1;
    end
    chk("abort_no_done", {7'd0, seen}, 8'd0);

    // Asynchronous reset while vector 1 is settling.
    pulse_start0();
    cyc = 1;
    while (cyc < 5) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("pre_rst_fv", {4'd0, fv0}, 8'h01);
    rst = 1'b1;
    #1;
    chk("rst_mid_ctl", {3'd0, a0, b0, busy0, done0, pass0}, 8'd0);
    chk("rst_mid_fv", {4'd0, fv0}, 8'd0);
    chk("rst_mid_ec", {5'd0, ec0}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    run0(2'd0, 1'b0, 4'b0000, 3'd0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
